// File: rtl/rr_switch_scheduler_pkg.sv
// switch_sched_pkg: shared types, destination codes and decode helper for the switch scheduler
package switch_sched_pkg;
  typedef enum logic [1:0] {IDLE, FETCH, ARB} state_t;
  typedef logic [1:0] port_t;
  localparam logic [1:0] DEST_P1 = 2'b01;
  localparam logic [1:0] DEST_P2A = 2'b00;
  localparam logic [1:0] DEST_P2B = 2'b10;
  localparam logic [1:0] DEST_P3 = 2'b11;
  function automatic port_t dest_decode(input logic [1:0] code);
    return (code == DEST_P2A || code == DEST_P2B) ? 2'd2 : code == DEST_P1 ? 2'd1 : 2'd3;
  endfunction
endpackage

// File: rtl/rr_switch_scheduler_if.sv
// rr_switch_scheduler_if: input queue RAM read side, output RAM write side and control of the scheduler
interface rr_switch_scheduler_if #(parameter int DATA_W = 32, parameter int ADDR_W = 12);
  logic enable;
  logic [DATA_W-1:0] input1, input2, input3;
  logic [ADDR_W-1:0] input_ram_wr_add1, input_ram_wr_add2, input_ram_wr_add3;
  logic out_ready1, out_ready2, out_ready3;
  logic [ADDR_W-1:0] input_ram_rd_add1, input_ram_rd_add2, input_ram_rd_add3;
  logic input_ram_rden1, input_ram_rden2, input_ram_rden3;
  logic [DATA_W-1:0] output1, output2, output3;
  logic out_ram_wr1, out_ram_wr2, out_ram_wr3;
  logic busy;
  modport master(
    input enable, input1, input2, input3,
    input input_ram_wr_add1, input_ram_wr_add2, input_ram_wr_add3,
    input out_ready1, out_ready2, out_ready3,
    output input_ram_rd_add1, input_ram_rd_add2, input_ram_rd_add3,
    output input_ram_rden1, input_ram_rden2, input_ram_rden3,
    output output1, output2, output3,
    output out_ram_wr1, out_ram_wr2, out_ram_wr3, busy
  );
  modport slave(
    output enable, input1, input2, input3,
    output input_ram_wr_add1, input_ram_wr_add2, input_ram_wr_add3,
    output out_ready1, out_ready2, out_ready3,
    input input_ram_rd_add1, input_ram_rd_add2, input_ram_rd_add3,
    input input_ram_rden1, input_ram_rden2, input_ram_rden3,
    input output1, output2, output3,
    input out_ram_wr1, out_ram_wr2, out_ram_wr3, busy
  );
endinterface

// File: rtl/rr_switch_scheduler_arb3.sv
// rr_arb3: combinational 3-way round-robin arbiter, scan starts at the pointed input
module rr_arb3
  import switch_sched_pkg::*;
(
  input  logic [2:0] req,
  input  port_t      ptr,
  output logic [2:0] gnt
);
  logic [1:0] base;
  logic [2:0] r, f;
  // rotate requests so the priority input sits at bit 0, pick the first, rotate back
  always_comb begin
    base = ptr == 2'd3 ? 2'd2 : ptr == 2'd2 ? 2'd1 : 2'd0;
    r = base == 2'd1 ? {req[0], req[2:1]} : base == 2'd2 ? {req[1:0], req[2]} : req;
    f = r[0] ? 3'b001 : r[1] ? 3'b010 : r[2] ? 3'b100 : 3'b000;
    gnt = base == 2'd1 ? {f[1:0], f[2]} : base == 2'd2 ? {f[0], f[2:1]} : f;
  end
endmodule

// File: rtl/rr_switch_scheduler.sv
// rr_switch_scheduler: 3x3 switch scheduler routing queue heads to output RAMs with per-output round-robin
module rr_switch_scheduler
  import switch_sched_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 12
) (
  input logic clk,
  input logic reset,
  rr_switch_scheduler_if.master bus
);
  state_t state;
  logic [DATA_W-1:0] din [3];
  logic [DATA_W-1:0] dout [3];
  logic [ADDR_W-1:0] wr_add [3];
  logic [ADDR_W-1:0] rd_add [3];
  port_t ptr [3];
  logic [2:0] req [3];
  logic [2:0] gnt [3];
  logic [2:0] gv [3];
  logic [2:0] ready, wr, ne, adv;
  assign din[0] = bus.input1;
  assign din[1] = bus.input2;
  assign din[2] = bus.input3;
  assign wr_add[0] = bus.input_ram_wr_add1;
  assign wr_add[1] = bus.input_ram_wr_add2;
  assign wr_add[2] = bus.input_ram_wr_add3;
  assign ready = {bus.out_ready3, bus.out_ready2, bus.out_ready1};
  // requests from non-empty queues by head destination; grants only count in ARB with the output ready
  always_comb begin
    ne = '0;
    adv = '0;
    for (int i = 0; i < 3; i++) ne[i] = rd_add[i] != wr_add[i];
    for (int o = 0; o < 3; o++) begin
      req[o] = '0;
      for (int i = 0; i < 3; i++) req[o][i] = ne[i] && dest_decode(din[i][1:0]) == port_t'(o + 1);
      gv[o] = gnt[o] & {3{ready[o] && state == ARB}};
    end
    for (int i = 0; i < 3; i++) adv[i] = gv[0][i] | gv[1][i] | gv[2][i];
  end
  for (genvar g = 0; g < 3; g++) begin : g_arb
    rr_arb3 u_arb (.req(req[g]), .ptr(ptr[g]), .gnt(gnt[g]));
  end
  // FSM, read pointers, output registers and priority pointers
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      wr <= '0;
      for (int k = 0; k < 3; k++) begin
        rd_add[k] <= '0;
        dout[k] <= '0;
        ptr[k] <= 2'd1;
      end
    end else begin
      state <= state == IDLE ? (bus.enable ? FETCH : IDLE) : state == FETCH ? ARB : (bus.enable ? FETCH : IDLE);
      for (int k = 0; k < 3; k++) begin
        wr[k] <= |gv[k];
        rd_add[k] <= rd_add[k] + ADDR_W'(adv[k]);
        if (|gv[k]) begin
          dout[k] <= gv[k][0] ? din[0] : gv[k][1] ? din[1] : din[2];
          ptr[k] <= gv[k][0] ? 2'd2 : gv[k][1] ? 2'd3 : 2'd1;
        end
      end
    end
  end
  assign bus.busy = state != IDLE;
  assign bus.input_ram_rden1 = state != IDLE;
  assign bus.input_ram_rden2 = state != IDLE;
  assign bus.input_ram_rden3 = state != IDLE;
  assign bus.input_ram_rd_add1 = rd_add[0];
  assign bus.input_ram_rd_add2 = rd_add[1];
  assign bus.input_ram_rd_add3 = rd_add[2];
  assign bus.output1 = dout[0];
  assign bus.output2 = dout[1];
  assign bus.output3 = dout[2];
  assign bus.out_ram_wr1 = wr[0];
  assign bus.out_ram_wr2 = wr[1];
  assign bus.out_ram_wr3 = wr[2];
endmodule

// File: tb/tb_rr_switch_scheduler.sv
// tb_rr_switch_scheduler: directed checks of routing, round-robin, backpressure, wrap and reset
module tb_rr_switch_scheduler;
  logic clk = 1'b0;
  logic reset = 1'b1;
  int total = 0, bad = 0;
  int n1 = 0, n2 = 0, n3 = 0;
  logic [31:0] mem1 [4096];
  logic [31:0] mem2 [4096];
  logic [31:0] mem3 [4096];
  rr_switch_scheduler_if bus();
  rr_switch_scheduler dut(.clk(clk), .reset(reset), .bus(bus.master));
  always #5 clk = ~clk;
  // synchronous input RAMs and output strobe counters
  always @(posedge clk) begin
    if (bus.input_ram_rden1) bus.input1 <= mem1[bus.input_ram_rd_add1];
    if (bus.input_ram_rden2) bus.input2 <= mem2[bus.input_ram_rd_add2];
    if (bus.input_ram_rden3) bus.input3 <= mem3[bus.input_ram_rd_add3];
    if (bus.out_ram_wr1) n1 <= n1 + 1;
    if (bus.out_ram_wr2) n2 <= n2 + 1;
    if (bus.out_ram_wr3) n3 <= n3 + 1;
  end
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask
  task automatic idle();
    bus.enable = 1'b0;
    step(3);
  endtask
  initial begin
    int i, k, c0, cnt;
    logic [11:0] ra;
    logic [11:0] base;
    bus.enable = 1'b1;
    bus.input1 = '0;
    bus.input2 = '0;
    bus.input3 = '0;
    bus.input_ram_wr_add1 = '0;
    bus.input_ram_wr_add2 = '0;
    bus.input_ram_wr_add3 = '0;
    bus.out_ready1 = 1'b1;
    bus.out_ready2 = 1'b1;
    bus.out_ready3 = 1'b1;
    step(2);
    chk("rst_rd1", bus.input_ram_rd_add1, 0);
    chk("rst_rd2", bus.input_ram_rd_add2, 0);
    chk("rst_rd3", bus.input_ram_rd_add3, 0);
    chk("rst_wr", {bus.out_ram_wr3, bus.out_ram_wr2, bus.out_ram_wr1}, 0);
    chk("rst_out1", bus.output1, 0);
    chk("rst_out2", bus.output2, 0);
    chk("rst_out3", bus.output3, 0);
    chk("rst_busy", bus.busy, 0);
    chk("rst_rden", bus.input_ram_rden1, 0);
    reset = 1'b0;
    step(1);
    chk("busy_after_rst", bus.busy, 1);
    idle();
    chk("idle_rden", bus.input_ram_rden1, 0);
    chk("idle_busy", bus.busy, 0);
    mem1[0] = 32'h0000_0013;
    bus.input_ram_wr_add1 = 12'd1;
    bus.enable = 1'b1;
    step(1);
    chk("fetch_rden", bus.input_ram_rden1, 1);
    step(1);
    chk("arb_rden", bus.input_ram_rden1, 1);
    chk("arb_wr3", bus.out_ram_wr3, 0);
    step(1);
    chk("single_wr3", bus.out_ram_wr3, 1);
    chk("single_out3", bus.output3, 32'h13);
    chk("single_rd1", bus.input_ram_rd_add1, 1);
    chk("single_wr1", bus.out_ram_wr1, 0);
    step(1);
    chk("single_wr3_drop", bus.out_ram_wr3, 0);
    idle();
    for (int j = 0; j < 3; j++) begin
      mem1[1 + j] = (32'd1 << 12) | (32'(j) << 8) | 32'd1;
      mem2[j] = (32'd2 << 12) | (32'(j) << 8) | 32'd1;
      mem3[j] = (32'd3 << 12) | (32'(j) << 8) | 32'd1;
    end
    bus.input_ram_wr_add1 = 12'd4;
    bus.input_ram_wr_add2 = 12'd3;
    bus.input_ram_wr_add3 = 12'd3;
    bus.enable = 1'b1;
    for (int g = 0; g < 9; g++) begin
      i = g % 3 + 1;
      k = g / 3;
      step(g == 0 ? 3 : 1);
      chk("coll_wr1", bus.out_ram_wr1, 1);
      chk("coll_out1", bus.output1, (32'(i) << 12) | (32'(k) << 8) | 32'd1);
      ra = i == 1 ? bus.input_ram_rd_add1 : i == 2 ? bus.input_ram_rd_add2 : bus.input_ram_rd_add3;
      base = i == 1 ? 12'd1 : 12'd0;
      chk("coll_rd", ra, base + 12'(k) + 12'd1);
      step(1);
      chk("coll_gap", bus.out_ram_wr1, 0);
    end
    idle();
    chk("coll_end_rd1", bus.input_ram_rd_add1, 4);
    chk("coll_end_rd3", bus.input_ram_rd_add3, 3);
    bus.out_ready2 = 1'b0;
    mem2[3] = 32'h0000_AB02;
    bus.input_ram_wr_add2 = 12'd4;
    bus.enable = 1'b1;
    for (int j = 0; j < 5; j++) begin
      step(1);
      chk("bp_wr2", bus.out_ram_wr2, 0);
      chk("bp_rd2", bus.input_ram_rd_add2, 3);
    end
    bus.out_ready2 = 1'b1;
    step(2);
    chk("bp_rel_wr2", bus.out_ram_wr2, 1);
    chk("bp_rel_out2", bus.output2, 32'h0000_AB02);
    chk("bp_rel_rd2", bus.input_ram_rd_add2, 4);
    idle();
    for (int a = 4; a < 4095; a++) mem1[a] = (32'(a) << 8) | 32'd1;
    mem1[4095] = 32'h0000_0C03;
    bus.input_ram_wr_add1 = 12'hFFF;
    c0 = n1;
    cnt = 0;
    bus.enable = 1'b1;
    while (bus.input_ram_rd_add1 != 12'hFFF && cnt < 10000) begin
      step(1);
      cnt++;
    end
    chk("wrap_reach", bus.input_ram_rd_add1, 12'hFFF);
    idle();
    chk("bulk_count", n1 - c0, 4091);
    chk("bulk_last", bus.output1, 32'h000F_FE01);
    c0 = n3;
    bus.input_ram_wr_add1 = 12'h000;
    bus.enable = 1'b1;
    step(3);
    chk("wrap_wr3", bus.out_ram_wr3, 1);
    chk("wrap_out3", bus.output3, 32'h0000_0C03);
    chk("wrap_rd1", bus.input_ram_rd_add1, 0);
    step(10);
    chk("wrap_hold_rd1", bus.input_ram_rd_add1, 0);
    chk("wrap_one_grant", n3 - c0, 1);
    idle();
    mem2[4] = 32'h0000_5501;
    bus.input_ram_wr_add2 = 12'd5;
    bus.enable = 1'b1;
    step(2);
    chk("mid_arb_busy", bus.busy, 1);
    reset = 1'b1;
    step(1);
    chk("mid_rst_wr1", bus.out_ram_wr1, 0);
    chk("mid_rst_out1", bus.output1, 0);
    chk("mid_rst_rd1", bus.input_ram_rd_add1, 0);
    chk("mid_rst_rd2", bus.input_ram_rd_add2, 0);
    chk("mid_rst_rd3", bus.input_ram_rd_add3, 0);
    chk("mid_rst_busy", bus.busy, 0);
    reset = 1'b0;
    bus.enable = 1'b0;
    step(2);
    chk("post_rst_idle", bus.busy, 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
